// File: rtl/sample_tx_buffer.sv
// Captures one 32-bit sample per drdy falling edge and serves it to the I2C read port byte-by-byte.
// Optional SAMPLE_TXBUF_HDR_EN prefixes each sample with a {3'b101, sample_idx} header byte.
module sample_tx_buffer #(
    parameter int NUM_PX     = 24,
    parameter int SETTLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        drdy,
    input  logic [31:0] sample_in,
    input  logic        rd_req,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    output logic        tx_avail,
    output logic        ack_received,
    output logic        overrun
);

`ifdef SAMPLE_TXBUF_HDR_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC - 1);
    localparam logic [4:0] IDX_WRAP    = 5'(NUM_PX - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LOAD,
        ST_SERVE,
        ST_ACK
    } state_t;

    state_t      state_q, state_d;
    logic        drdy_q;
    logic [3:0]  settle_cnt_q, settle_cnt_d;
    logic [31:0] shreg_q, shreg_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [4:0]  sample_idx_q, sample_idx_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_valid_q, tx_valid_d;
    logic        ack_q, ack_d;
    logic        overrun_q, overrun_d;
    logic        fall;
    logic [7:0]  cur_byte;

    // drdy_q resets low so an undefined drdy after reset cannot look like a fall.
    assign fall = drdy_q & ~drdy;

    always_comb begin
        cur_byte = shreg_q[7:0];
        case (byte_idx_q)
`ifdef SAMPLE_TXBUF_HDR_EN
            3'd0:    cur_byte = {3'b101, sample_idx_q};
            3'd1:    cur_byte = shreg_q[31:24];
            3'd2:    cur_byte = shreg_q[23:16];
            3'd3:    cur_byte = shreg_q[15:8];
            default: cur_byte = shreg_q[7:0];
`else
            3'd0:    cur_byte = shreg_q[31:24];
            3'd1:    cur_byte = shreg_q[23:16];
            3'd2:    cur_byte = shreg_q[15:8];
            default: cur_byte = shreg_q[7:0];
`endif
        endcase
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        shreg_d      = shreg_q;
        byte_idx_d   = byte_idx_q;
        sample_idx_d = sample_idx_q;
        tx_byte_d    = tx_byte_q;
        tx_valid_d   = 1'b0;
        ack_d        = 1'b0;
        overrun_d    = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = SETTLE_INIT;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == 4'd0) begin
                    state_d = ST_LOAD;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end
            ST_LOAD: begin
                shreg_d    = sample_in;
                byte_idx_d = 3'd0;
                state_d    = ST_SERVE;
            end
            ST_SERVE: begin
                if (fall) begin
                    overrun_d = 1'b1;
                end
                if (rd_req) begin
                    tx_valid_d = 1'b1;
                    tx_byte_d  = cur_byte;
                    if (byte_idx_q == LAST_IDX) begin
                        state_d = ST_ACK;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
            ST_ACK: begin
                if (fall) begin
                    overrun_d = 1'b1;
                end
                ack_d        = 1'b1;
                sample_idx_d = (sample_idx_q == IDX_WRAP) ? 5'd0 : sample_idx_q + 5'd1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            drdy_q       <= 1'b0;
            settle_cnt_q <= 4'd0;
            shreg_q      <= 32'd0;
            byte_idx_q   <= 3'd0;
            sample_idx_q <= 5'd0;
            tx_byte_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            ack_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            drdy_q       <= drdy;
            settle_cnt_q <= settle_cnt_d;
            shreg_q      <= shreg_d;
            byte_idx_q   <= byte_idx_d;
            sample_idx_q <= sample_idx_d;
            tx_byte_q    <= tx_byte_d;
            tx_valid_q   <= tx_valid_d;
            ack_q        <= ack_d;
            overrun_q    <= overrun_d;
        end
    end

    assign tx_byte      = tx_byte_q;
    assign tx_valid     = tx_valid_q;
    assign tx_avail     = (state_q == ST_SERVE);
    assign ack_received = ack_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_sample_tx_buffer.sv
// Directed self-checking bench for sample_tx_buffer (SETTLE_CYC = 4, NUM_PX = 24).
// Build with SAMPLE_TXBUF_HDR_EN defined to also exercise the header bytes and index wrap.
module tb_sample_tx_buffer;

    logic        clk;
    logic        rst;
    logic        drdy;
    logic [31:0] sample_in;
    logic        rd_req;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_avail;
    logic        ack_received;
    logic        overrun;

    int checkCount = 0;
    int errorCount = 0;
    int sampleIdx  = 0;

`ifdef SAMPLE_TXBUF_HDR_EN
    localparam int NUM_BYTES = 5;
`else
    localparam int NUM_BYTES = 4;
`endif

    sample_tx_buffer #(
        .NUM_PX    (24),
        .SETTLE_CYC(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .drdy        (drdy),
        .sample_in   (sample_in),
        .rd_req      (rd_req),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_avail    (tx_avail),
        .ack_received(ack_received),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic d, input logic [31:0] s, input logic r);
        drdy      = d;
        sample_in = s;
        rd_req    = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] expByte(input logic [31:0] value, input int idx, input int sIdx);
        logic [31:0] v;
        int          d;
        v = value;
`ifdef SAMPLE_TXBUF_HDR_EN
        if (idx == 0) return {3'b101, 5'(sIdx)};
        d = idx - 1;
`else
        d = idx + (sIdx * 0);
`endif
        return v[31 - 8*d -: 8];
    endfunction

    // Rising then falling drdy, checking the SETTLE_CYC+2 latency to tx_avail.
    task automatic doFall(input logic [31:0] value);
        applyStimulus(1'b1, value, 1'b0);
        tick();
        applyStimulus(1'b0, value, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("avail_early", 32'(tx_avail), 32'd0);
        tick();
        checkOutput("avail_rise", 32'(tx_avail), 32'd1);
    endtask

    task automatic readBytes(input logic [31:0] value, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            rd_req = 1'b1;
            tick();
            checkOutput($sformatf("valid%0d", i), 32'(tx_valid), 32'd1);
            checkOutput($sformatf("byte%0d", i), 32'(tx_byte), 32'(expByte(value, i, sampleIdx)));
        end
        rd_req = 1'b0;
        if (last == NUM_BYTES - 1) begin
            checkOutput("avail_fall", 32'(tx_avail), 32'd0);
            checkOutput("ack_early", 32'(ack_received), 32'd0);
            tick();
            checkOutput("ack_pulse", 32'(ack_received), 32'd1);
            checkOutput("valid_drop", 32'(tx_valid), 32'd0);
            tick();
            checkOutput("ack_single", 32'(ack_received), 32'd0);
            sampleIdx = (sampleIdx == 23) ? 0 : sampleIdx + 1;
        end
    endtask

    initial begin
        int acks;
        int avails;
        int valids;

        // Reset with drdy held low throughout
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("rst_byte", 32'(tx_byte), 32'h00);
        checkOutput("rst_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_avail", 32'(tx_avail), 32'd0);
        checkOutput("rst_ack", 32'(ack_received), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b1;
        acks = 0;
        avails = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            acks += int'(ack_received);
            avails += int'(tx_avail);
        end
        checkOutput("rst_no_ack", 32'(acks), 32'd0);
        checkOutput("rst_no_avail", 32'(avails), 32'd0);

        // Basic sample
        doFall(32'hDEADBEEF);
        readBytes(32'hDEADBEEF, 0, NUM_BYTES - 1);

        // Stray reads in IDLE/SETTLE; sample_in churns until LOAD
        applyStimulus(1'b1, 32'hAAAAAAAA, 1'b1);
        tick();
        checkOutput("stray_idle_valid", 32'(tx_valid), 32'd0);
        applyStimulus(1'b0, 32'hAAAAAAAA, 1'b1);
        valids = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            valids += int'(tx_valid);
            sample_in = (i == 5) ? 32'h12345678 : {8'(i), 24'hC0FFEE};
            rd_req    = (i < 5);
        end
        checkOutput("stray_valid", 32'(valids), 32'd0);
        checkOutput("stray_hold", 32'(tx_byte), 32'hEF);
        tick();
        checkOutput("stray_avail", 32'(tx_avail), 32'd1);
        sample_in = 32'hFFFFFFFF;
        readBytes(32'h12345678, 0, NUM_BYTES - 1);

        // Overrun after two bytes; second fall coincides with a read
        doFall(32'h89ABCDEF);
        readBytes(32'h89ABCDEF, 0, 1);
        applyStimulus(1'b1, 32'h55555555, 1'b0);
        tick();
        checkOutput("ovr_before", 32'(overrun), 32'd0);
        applyStimulus(1'b0, 32'h55555555, 1'b1);
        tick();
        rd_req = 1'b0;
        checkOutput("ovr_set", 32'(overrun), 32'd1);
        checkOutput("ovr_rd_valid", 32'(tx_valid), 32'd1);
        checkOutput("ovr_rd_byte", 32'(tx_byte), 32'(expByte(32'h89ABCDEF, 2, sampleIdx)));
        readBytes(32'h89ABCDEF, 3, NUM_BYTES - 1);
        acks = 0;
        avails = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            acks += int'(ack_received);
            avails += int'(tx_avail);
        end
        checkOutput("ovr_no_extra_ack", 32'(acks), 32'd0);
        checkOutput("ovr_dropped", 32'(avails), 32'd0);
        checkOutput("ovr_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of SERVE
        doFall(32'h0BADF00D);
        readBytes(32'h0BADF00D, 0, 0);
        rst = 1'b0;
        tick();
        checkOutput("mid_rst_avail", 32'(tx_avail), 32'd0);
        checkOutput("mid_rst_byte", 32'(tx_byte), 32'h00);
        checkOutput("mid_rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b1;
        sampleIdx = 0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            acks += int'(ack_received);
        end
        checkOutput("mid_rst_no_ack", 32'(acks), 32'd0);
        doFall(32'hCAFEF00D);
        readBytes(32'hCAFEF00D, 0, NUM_BYTES - 1);

`ifdef SAMPLE_TXBUF_HDR_EN
        // Run past NUM_PX samples so the header index wraps back to A0
        for (int n = 0; n < 25; n++) begin
            doFall(32'(n) * 32'h01010101);
            readBytes(32'(n) * 32'h01010101, 0, NUM_BYTES - 1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
